// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, load-wait sequencing and register-file write port
module writeback_stage #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xm_valid,
    input  logic        xm_RegWrite,
    input  logic        xm_MemRead,
    input  logic        xm_MemtoReg,
    input  logic        xm_is_JAL,
    input  logic        xm_halt,
    input  logic [2:0]  xm_writeReg,
    input  logic [15:0] xm_alu_result,
    input  logic [15:0] xm_PC_2,
    input  logic        mem_done,
    input  logic        mem_err,
    input  logic [15:0] mem_data_out,
    output logic        wb_stall,
    output logic        mw_RegWrite,
    output logic [2:0]  regWrSel,
    output logic [15:0] write_data,
    output logic        pend_valid,
    output logic [2:0]  pend_reg,
    output logic        halt,
    output logic        err,
    output logic [15:0] retired_count
);

    typedef enum logic [1:0] {EMPTY, HOLD, WAIT_MEM, HALTED} state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic        jal_q, jal_d;
    logic        halt_pend_q, halt_pend_d;
    logic [2:0]  wreg_q, wreg_d;
    logic [15:0] alu_q, alu_d;
    logic [15:0] pc2_q, pc2_d;
    logic [15:0] ld_q, ld_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        halt_q, halt_d;
    logic        err_q, err_d;
    logic [15:0] ret_q, ret_d;
    logic [7:0]  cnt_inc;
    logic        accept;

    // A committing HALT stalls too, so an offered instruction is never silently dropped.
    assign wb_stall = (state_q == WAIT_MEM) || (state_q == HALTED) ||
                      ((state_q == HOLD) && halt_pend_q);
    assign accept   = xm_valid && !wb_stall && ((state_q == EMPTY) || (state_q == HOLD));
    assign cnt_inc  = cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        m2r_d       = m2r_q;
        jal_d       = jal_q;
        halt_pend_d = halt_pend_q;
        wreg_d      = wreg_q;
        alu_d       = alu_q;
        pc2_d       = pc2_q;
        ld_d        = ld_q;
        cnt_d       = cnt_q;
        halt_d      = halt_q;
        err_d       = err_q;
        ret_d       = ret_q;

        case (state_q)
            HOLD: begin
                ret_d = ret_q + 16'd1;
                if (halt_pend_q) begin
                    state_d     = HALTED;
                    halt_d      = 1'b1;
                    halt_pend_d = 1'b0;
                end else begin
                    state_d = EMPTY;
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_inc;
                if (mem_err) begin
                    err_d   = 1'b1;
                    state_d = HALTED;
                    cnt_d   = 8'd0;
                end else if (mem_done) begin
                    ld_d    = mem_data_out;
                    state_d = HOLD;
                    cnt_d   = 8'd0;
                end else if (cnt_inc >= TMO) begin
                    err_d   = 1'b1;
                    state_d = HALTED;
                    cnt_d   = 8'd0;
                end
            end
            default: ;
        endcase

        // Acceptance overrides the HOLD->EMPTY default so ALU ops stream back to back.
        if (accept) begin
            rw_d        = xm_RegWrite;
            m2r_d       = xm_MemtoReg;
            jal_d       = xm_is_JAL;
            halt_pend_d = xm_halt;
            wreg_d      = xm_writeReg;
            alu_d       = xm_alu_result;
            pc2_d       = xm_PC_2;
            state_d     = (xm_halt || !xm_MemRead) ? HOLD : WAIT_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            rw_q        <= 1'b0;
            m2r_q       <= 1'b0;
            jal_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            wreg_q      <= 3'd0;
            alu_q       <= 16'd0;
            pc2_q       <= 16'd0;
            ld_q        <= 16'd0;
            cnt_q       <= 8'd0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            ret_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            m2r_q       <= m2r_d;
            jal_q       <= jal_d;
            halt_pend_q <= halt_pend_d;
            wreg_q      <= wreg_d;
            alu_q       <= alu_d;
            pc2_q       <= pc2_d;
            ld_q        <= ld_d;
            cnt_q       <= cnt_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
            ret_q       <= ret_d;
        end
    end

    // Select and data come straight from the latch, so they keep the last commit while EMPTY.
    assign mw_RegWrite   = (state_q == HOLD) && rw_q;
    assign regWrSel      = wreg_q;
    assign write_data    = jal_q ? pc2_q : (m2r_q ? ld_q : alu_q);
    assign pend_valid    = (state_q == WAIT_MEM) && rw_q;
    assign pend_reg      = (state_q == WAIT_MEM) ? wreg_q : 3'd0;
    assign halt          = halt_q;
    assign err           = err_q;
    assign retired_count = ret_q;

endmodule
